// File: rtl/bcd_timer_chain.sv
// Tick-enabled BCD counter chain with per-digit modulus, up/down, load, wrap pulse and alarm FSM.
// Optional lap capture register enabled by defining BCD_TIMER_LAP_EN.

module bcd_timer_digit #(
  parameter logic [3:0] MOD = 4'd10
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       step,
  input  logic       up,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_zero
);
  localparam logic [3:0] MAX = MOD - 4'd1;

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      // out-of-range load values saturate at the top of the digit
      digit_d = (load_nib >= MOD) ? MAX : load_nib;
    end else if (step) begin
      if (up) digit_d = (digit_q == MAX)  ? 4'd0 : digit_q + 4'd1;
      else    digit_d = (digit_q == 4'd0) ? MAX  : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) digit_q <= 4'd0;
    else          digit_q <= digit_d;
  end

  assign q       = digit_q;
  assign at_max  = (digit_q == MAX);
  assign at_zero = (digit_q == 4'd0);
endmodule

module bcd_timer_chain #(
  parameter int                     DIGITS     = 4,
  parameter logic [4*DIGITS-1:0]    MODS       = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter bit                     ALARM_HOLD = 1'b0
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  tick,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   alarm_val,
  input  logic                  alarm_arm,
  input  logic                  alarm_ack,
`ifdef BCD_TIMER_LAP_EN
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_count,
  output logic                  lap_valid,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry_out,
  output logic                  alarm_hit,
  output logic                  ringing
);
  typedef enum logic [1:0] {DISARMED, ARMED, RINGING, ACKED} alarm_state_e;

  logic [DIGITS-1:0][3:0] digit_q;
  logic [DIGITS-1:0]      at_max, at_zero, term;
  logic [DIGITS:0]        en;
  logic                   wrap;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      bcd_timer_digit #(.MOD(MODS[4*i +: 4])) u_digit (
        .clk      (clk),
        .clear_n  (clear_n),
        .load     (load),
        .load_nib (load_val[4*i +: 4]),
        .step     (tick & en[i]),
        .up       (up_down),
        .q        (digit_q[i]),
        .at_max   (at_max[i]),
        .at_zero  (at_zero[i])
      );
      assign term[i] = up_down ? at_max[i] : at_zero[i];
    end
  endgenerate

  // en[i]: every digit below i sits at its terminal value for the current direction
  always_comb begin
    en    = '0;
    en[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) en[k+1] = en[k] & term[k];
  end

  assign count = digit_q;
  assign wrap  = tick & ~load & en[DIGITS];

  logic carry_q, carry_d;
  assign carry_d = wrap;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) carry_q <= 1'b0;
    else          carry_q <= carry_d;
  end
  assign carry_out = carry_q;

  logic match;
  assign match = (count == alarm_val);

  alarm_state_e state_q, state_d;
  logic         hit_q, hit_d, ring_q, ring_d;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= DISARMED;
      hit_q   <= 1'b0;
      ring_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      ring_q  <= ring_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISARMED: if (alarm_arm) state_d = ARMED;
      ARMED: begin
        if (!alarm_arm) state_d = DISARMED;
        else if (match) state_d = RINGING;
      end
      RINGING: begin
        if (!alarm_arm)                    state_d = DISARMED;
        else if (alarm_ack)                state_d = ACKED;
        else if (!ALARM_HOLD && !match)    state_d = ARMED;
      end
      ACKED: begin
        if (!alarm_arm)  state_d = DISARMED;
        else if (!match) state_d = ARMED;
      end
      default: state_d = DISARMED;
    endcase
  end

  // outputs are registered copies of the upcoming state
  always_comb begin
    hit_d  = (state_q != RINGING) && (state_d == RINGING);
    ring_d = (state_d == RINGING);
  end

  assign alarm_hit = hit_q;
  assign ringing   = ring_q;

`ifdef BCD_TIMER_LAP_EN
  logic [4*DIGITS-1:0] lap_count_q, lap_count_d;
  logic                lap_valid_q, lap_valid_d;

  // capture samples the registered count, i.e. the value before any same-cycle tick
  always_comb begin
    lap_count_d = lap ? count : lap_count_q;
    lap_valid_d = load ? 1'b0 : (lap | lap_valid_q);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      lap_count_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_count_q <= lap_count_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_count = lap_count_q;
  assign lap_valid = lap_valid_q;
`endif
endmodule

// File: tb/tb_bcd_timer_chain.sv
// Directed bench for bcd_timer_chain: one instance per ALARM_HOLD setting, shared stimulus.
module tb_bcd_timer_chain;
  logic        clk = 1'b0;
  logic        clear_n, tick, up_down, load, alarm_arm, alarm_ack;
  logic [15:0] load_val, alarm_val;
  logic [15:0] count0, count1;
  logic        carry0, carry1, hit0, hit1, ring0, ring1;
  int          total = 0;
  int          bad = 0;

  bcd_timer_chain #(.ALARM_HOLD(1'b0)) u0 (
    .clk(clk), .clear_n(clear_n), .tick(tick), .up_down(up_down), .load(load),
    .load_val(load_val), .alarm_val(alarm_val), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .count(count0), .carry_out(carry0), .alarm_hit(hit0), .ringing(ring0));

  bcd_timer_chain #(.ALARM_HOLD(1'b1)) u1 (
    .clk(clk), .clear_n(clear_n), .tick(tick), .up_down(up_down), .load(load),
    .load_val(load_val), .alarm_val(alarm_val), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .count(count1), .carry_out(carry1), .alarm_hit(hit1), .ringing(ring1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic load_once(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    clear_n = 1'b0; tick = 1'b0; up_down = 1'b1; load = 1'b0;
    alarm_arm = 1'b0; alarm_ack = 1'b0; load_val = '0; alarm_val = '0;
    #3;
    chk("rst_count", count0, 16'h0000);
    chk("rst_carry", carry0, 1'b0);
    chk("rst_hit",   hit0,   1'b0);
    chk("rst_ring",  ring0,  1'b0);
    #8 clear_n = 1'b1;

    // up count and full wrap
    load_once(16'h5958);
    chk("load_5958", count0, 16'h5958);
    tick_once();
    chk("up_5959", count0, 16'h5959);
    chk("up_5959_carry", carry0, 1'b0);
    tick_once();
    chk("up_wrap", count0, 16'h0000);
    chk("up_wrap_carry", carry0, 1'b1);
    step();
    chk("carry_one_cycle", carry0, 1'b0);

    // down count
    load_once(16'h0000);
    up_down = 1'b0;
    tick_once();
    chk("down_wrap", count0, 16'h5959);
    chk("down_wrap_carry", carry0, 1'b1);
    tick_once();
    chk("down_5958", count0, 16'h5958);
    chk("down_5958_carry", carry0, 1'b0);

    // mid-chain ripple both directions
    up_down = 1'b1;
    load_once(16'h0959);
    tick_once();
    chk("ripple_up", count0, 16'h1000);
    up_down = 1'b0;
    tick_once();
    chk("ripple_down", count0, 16'h0959);

    // clamp, then load beats a wrapping tick
    load_once(16'h7A9C);
    chk("clamp", count0, 16'h5959);
    up_down = 1'b1;
    tick = 1'b1;
    load_once(16'h1234);
    tick = 1'b0;
    chk("load_over_tick", count0, 16'h1234);
    chk("load_no_carry", carry0, 1'b0);

    // alarm ring / ack / re-ring
    alarm_val = 16'h0003;
    alarm_arm = 1'b1;
    load_once(16'h0000);
    tick_once(); tick_once(); tick_once();
    chk("cnt_0003", count0, 16'h0003);
    chk("ring_not_yet", ring0, 1'b0);
    step();
    chk("hit_pulse", hit0, 1'b1);
    chk("ring_on", ring0, 1'b1);
    step();
    chk("hit_one_cycle", hit0, 1'b0);
    chk("ring_stays", ring0, 1'b1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("ack_silences", ring0, 1'b0);
    step();
    chk("no_rering", ring0, 1'b0);
    chk("no_rering_hit", hit0, 1'b0);
    tick_once();
    chk("cnt_0004", count0, 16'h0004);
    step();
    load_once(16'h0003);
    chk("reload_no_ring_yet", ring0, 1'b0);
    step();
    chk("rering", ring0, 1'b1);
    chk("rering_hit", hit0, 1'b1);

    // ALARM_HOLD difference
    tick_once();
    chk("hold0_ring_m", ring0, 1'b1);
    step();
    chk("hold0_drops", ring0, 1'b0);
    chk("hold1_stays", ring1, 1'b1);
    alarm_arm = 1'b0;
    step();
    chk("hold1_disarm", ring1, 1'b0);
    chk("hold0_disarm", ring0, 1'b0);

    // async reset while ringing
    alarm_val = 16'h0005;
    alarm_arm = 1'b1;
    step();
    tick_once();
    step();
    chk("ring_before_rst", ring0, 1'b1);
    chk("cnt_before_rst", count0, 16'h0005);
    #2 clear_n = 1'b0;
    #1;
    chk("async_count", count0, 16'h0000);
    chk("async_ring", ring0, 1'b0);
    chk("async_ring1", ring1, 1'b0);
    chk("async_hit", hit0, 1'b0);
    chk("async_carry", carry0, 1'b0);
    #1 clear_n = 1'b1;
    tick_once();
    chk("post_rst_tick", count0, 16'h0001);
    chk("post_rst_tick1", count1, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
